// File: rtl/alu_pkg.sv
// Shared encodings and lane helper for the simd_alu_pipe block.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b100,
        OP_COPY = 3'b010
    } op_t;

    typedef enum logic [1:0] {
        VEC_CHAR   = 2'd0,
        VEC_HALF   = 2'd1,
        VEC_FULL   = 2'd2,
        VEC_DOUBLE = 2'd3
    } vec_t;

    function automatic int lane_bits(input vec_t v, input int w);
        case (v)
            VEC_CHAR: return 8;
            VEC_HALF: return 16;
            VEC_FULL: return w;
            default:  return 2 * w;
        endcase
    endfunction

endpackage

// File: rtl/simd_alu_pipe_if.sv
// Operand/result handshake bundle for simd_alu_pipe; slave is the ALU side.
interface simd_alu_pipe_if #(
    parameter int W     = 32,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic               form;
    logic [1:0]         vec;
    logic [3:0]         copy_sel;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [W-1:0]       c;
    logic [W-1:0]       d;
    logic [TAG_W-1:0]   tag_in;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       y1;
    logic [W-1:0]       y2;
    logic [2*W/8-1:0]   carry;
    logic               illegal;
    logic [TAG_W-1:0]   tag_out;

    modport master (
        output in_valid, op, form, vec, copy_sel, a, b, c, d, tag_in, out_ready,
        input  in_ready, out_valid, y1, y2, carry, illegal, tag_out
    );

    modport slave (
        input  in_valid, op, form, vec, copy_sel, a, b, c, d, tag_in, out_ready,
        output in_ready, out_valid, y1, y2, carry, illegal, tag_out
    );
endinterface

// File: rtl/simd_addsub.sv
// Combinational 2W-bit byte-sliced adder/subtractor; carries are killed at lane starts chosen by vec.
module simd_addsub
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2*W-1:0]   x,
    input  logic [2*W-1:0]   y,
    input  logic             sub,
    input  vec_t             vec,
    output logic [2*W-1:0]   sum,
    output logic [2*W/8-1:0] carry
);
    localparam int NB = 2 * W / 8;

    logic [8:0] acc;
    logic       cin;
    int         lb;

    // Subtraction is x + ~y + 1 per lane, so borrow is the inverted carry out.
    always_comb begin
        sum   = '0;
        carry = '0;
        acc   = '0;
        cin   = sub;
        lb    = lane_bits(vec, W) / 8;
        for (int i = 0; i < NB; i++) begin
            if (i % lb == 0) cin = sub;
            acc = {1'b0, x[i*8 +: 8]} + {1'b0, (sub ? ~y[i*8 +: 8] : y[i*8 +: 8])} + {8'b0, cin};
            sum[i*8 +: 8] = acc[7:0];
            cin = acc[8];
            if ((i + 1) % lb == 0) carry[i] = acc[8] ^ sub;
        end
    end
endmodule

// File: rtl/simd_alu_pipe.sv
// Lane-partitioned ADD/SUB/COPY ALU, STAGES-deep pipeline with collapsing bubbles and valid/ready.
// Define ALU_SAT_EN to make ADD/SUB with form=1 saturate unsigned per lane.
module simd_alu_pipe
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    simd_alu_pipe_if.slave  bus
);
    localparam int NB = 2 * W / 8;

    typedef struct packed {
        logic [W-1:0]     y1;
        logic [W-1:0]     y2;
        logic [NB-1:0]    carry;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    function automatic logic [W-1:0] pick(input logic [1:0] s,
                                          input logic [W-1:0] pa, pb, pc, pd);
        case (s)
            2'd0:    return pa;
            2'd1:    return pb;
            2'd2:    return pc;
            default: return pd;
        endcase
    endfunction

    vec_t            vec;
    logic [W-1:0]    src1;
    logic [W-1:0]    src2;
    logic [2*W-1:0]  op_x;
    logic [2*W-1:0]  op_y;
    logic            add_sub;
    logic [2*W-1:0]  add_sum;
    logic [NB-1:0]   add_carry;
    logic [2*W-1:0]  arith;
    res_t            res;

    assign vec  = vec_t'(bus.vec);
    assign src1 = pick(bus.copy_sel[1:0], bus.a, bus.b, bus.c, bus.d);
    assign src2 = pick(bus.copy_sel[3:2], bus.a, bus.b, bus.c, bus.d);

    // COPY negate reuses the adder as 0 - {src1,src2}, giving lane-correct negation for free.
    always_comb begin
        op_x    = {bus.a, bus.b};
        op_y    = {bus.c, bus.d};
        add_sub = (bus.op == OP_SUB);
        if (bus.op == OP_COPY) begin
            op_x    = '0;
            op_y    = {src1, src2};
            add_sub = 1'b1;
        end
    end

    simd_addsub #(.W(W)) u_addsub (
        .x     (op_x),
        .y     (op_y),
        .sub   (add_sub),
        .vec   (vec),
        .sum   (add_sum),
        .carry (add_carry)
    );

`ifdef ALU_SAT_EN
    int lb;

    always_comb begin
        lb    = lane_bits(vec, W) / 8;
        arith = add_sum;
        for (int i = 0; i < NB; i++) begin
            if (bus.form && add_carry[(i / lb) * lb + lb - 1])
                arith[i*8 +: 8] = (bus.op == OP_SUB) ? 8'h00 : 8'hFF;
        end
    end
`else
    assign arith = add_sum;
`endif

    always_comb begin
        res     = '0;
        res.tag = bus.tag_in;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                {res.y1, res.y2} = arith;
                res.carry        = add_carry;
            end
            OP_COPY: {res.y1, res.y2} = bus.form ? add_sum : {src1, src2};
            default: res.illegal = 1'b1;
        endcase
    end

    res_t            stg     [STAGES];
    logic            stg_vld [STAGES];
    logic [STAGES-1:0] rdy;

    // A stage may load when the output drains or any slot at or after it is empty.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = bus.out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!stg_vld[j]) rdy[k] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_vld[0] <= 1'b0;
                    stg[0]     <= '0;
                end else if (rdy[0]) begin
                    stg_vld[0] <= bus.in_valid;
                    if (bus.in_valid) stg[0] <= res;
                end
            end
        end else begin : g_delay
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_vld[g] <= 1'b0;
                    stg[g]     <= '0;
                end else if (rdy[g]) begin
                    stg_vld[g] <= stg_vld[g-1];
                    if (stg_vld[g-1]) stg[g] <= stg[g-1];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = stg_vld[STAGES-1];
    assign bus.y1        = stg[STAGES-1].y1;
    assign bus.y2        = stg[STAGES-1].y2;
    assign bus.carry     = stg[STAGES-1].carry;
    assign bus.illegal   = stg[STAGES-1].illegal;
    assign bus.tag_out   = stg[STAGES-1].tag;
endmodule
